// File: rtl/pipe_stage_latches.sv
// Pipeline inter-stage register banks: F/D, D/X and M/W.
// Each bank is independent, every output is a flop output, and data is
// passed through bit-for-bit. Per-edge priority in each bank is
// reset > flush (IR only) > enable > hold.
module pipe_stage_latches #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,

    // F/D bank
    input  logic             fd_en,
    input  logic             fd_flush,
    input  logic [WIDTH-1:0] fd_ir_in,
    input  logic [WIDTH-1:0] fd_pc_in,
    output logic [WIDTH-1:0] fd_ir_out,
    output logic [WIDTH-1:0] fd_pc_out,

    // D/X bank
    input  logic             dx_en,
    input  logic             dx_flush,
    input  logic [WIDTH-1:0] dx_ir_in,
    input  logic [WIDTH-1:0] dx_pc_in,
    input  logic [WIDTH-1:0] dx_a_in,
    input  logic [WIDTH-1:0] dx_b_in,
    output logic [WIDTH-1:0] dx_ir_out,
    output logic [WIDTH-1:0] dx_pc_out,
    output logic [WIDTH-1:0] dx_a_out,
    output logic [WIDTH-1:0] dx_b_out,

    // M/W bank
    input  logic             mw_en,
    input  logic [WIDTH-1:0] mw_ir_in,
    input  logic [WIDTH-1:0] mw_o_in,
    input  logic [WIDTH-1:0] mw_d_in,
    output logic [WIDTH-1:0] mw_ir_out,
    output logic [WIDTH-1:0] mw_o_out,
    output logic [WIDTH-1:0] mw_d_out
);

    // ------------------------------------------------------------------
    // F/D bank
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fd_ir_q, fd_ir_d;
    logic [WIDTH-1:0] fd_pc_q, fd_pc_d;

    // F/D next state: the hold path selects the stored value, so inputs of a
    // disabled bank (even X/Z) never reach the flops. Flush only bubbles IR.
    always_comb begin
        fd_ir_d = fd_ir_q;
        fd_pc_d = fd_pc_q;
        if (fd_en) begin
            fd_ir_d = fd_ir_in;
            fd_pc_d = fd_pc_in;
        end
        if (fd_flush) begin
            fd_ir_d = '0;
        end
    end

    // F/D registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            fd_ir_q <= '0;
            fd_pc_q <= '0;
        end else begin
            fd_ir_q <= fd_ir_d;
            fd_pc_q <= fd_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // D/X bank
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] dx_ir_q, dx_ir_d;
    logic [WIDTH-1:0] dx_pc_q, dx_pc_d;
    logic [WIDTH-1:0] dx_a_q,  dx_a_d;
    logic [WIDTH-1:0] dx_b_q,  dx_b_d;

    // D/X next state: load on enable, hold otherwise; flush bubbles IR only.
    always_comb begin
        dx_ir_d = dx_ir_q;
        dx_pc_d = dx_pc_q;
        dx_a_d  = dx_a_q;
        dx_b_d  = dx_b_q;
        if (dx_en) begin
            dx_ir_d = dx_ir_in;
            dx_pc_d = dx_pc_in;
            dx_a_d  = dx_a_in;
            dx_b_d  = dx_b_in;
        end
        if (dx_flush) begin
            dx_ir_d = '0;
        end
    end

    // D/X registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            dx_ir_q <= '0;
            dx_pc_q <= '0;
            dx_a_q  <= '0;
            dx_b_q  <= '0;
        end else begin
            dx_ir_q <= dx_ir_d;
            dx_pc_q <= dx_pc_d;
            dx_a_q  <= dx_a_d;
            dx_b_q  <= dx_b_d;
        end
    end

    // ------------------------------------------------------------------
    // M/W bank (no flush: a NOP arrives only through mw_ir_in)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mw_ir_q, mw_ir_d;
    logic [WIDTH-1:0] mw_o_q,  mw_o_d;
    logic [WIDTH-1:0] mw_d_q,  mw_d_d;

    // M/W next state: load on enable, hold otherwise.
    always_comb begin
        mw_ir_d = mw_ir_q;
        mw_o_d  = mw_o_q;
        mw_d_d  = mw_d_q;
        if (mw_en) begin
            mw_ir_d = mw_ir_in;
            mw_o_d  = mw_o_in;
            mw_d_d  = mw_d_in;
        end
    end

    // M/W registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            mw_ir_q <= '0;
            mw_o_q  <= '0;
            mw_d_q  <= '0;
        end else begin
            mw_ir_q <= mw_ir_d;
            mw_o_q  <= mw_o_d;
            mw_d_q  <= mw_d_d;
        end
    end

    // Outputs are the flops themselves.
    assign fd_ir_out = fd_ir_q;
    assign fd_pc_out = fd_pc_q;
    assign dx_ir_out = dx_ir_q;
    assign dx_pc_out = dx_pc_q;
    assign dx_a_out  = dx_a_q;
    assign dx_b_out  = dx_b_q;
    assign mw_ir_out = mw_ir_q;
    assign mw_o_out  = mw_o_q;
    assign mw_d_out  = mw_d_q;

endmodule

// File: tb/tb_pipe_stage_latches.sv
// Bench for pipe_stage_latches: directed vector table, two hand-written
// multi-cycle sequences, then randomized traffic against a field-array model.
module tb_pipe_stage_latches;

  localparam int W  = 32;
  localparam int NF = 9;  // fd_ir fd_pc dx_ir dx_pc dx_a dx_b mw_ir mw_o mw_d

  typedef logic [NF*W-1:0] out_t;

  typedef struct packed {
    logic         rst;
    logic         fd_en;
    logic         fd_fl;
    logic         dx_en;
    logic         dx_fl;
    logic         mw_en;
    logic [W-1:0] fd_ir, fd_pc, dx_ir, dx_pc, dx_a, dx_b, mw_ir, mw_o, mw_d;
  } in_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         fd_en, fd_flush, dx_en, dx_flush, mw_en;
  logic [W-1:0] fd_ir_in, fd_pc_in, dx_ir_in, dx_pc_in, dx_a_in, dx_b_in;
  logic [W-1:0] mw_ir_in, mw_o_in, mw_d_in;
  logic [W-1:0] fd_ir_out, fd_pc_out, dx_ir_out, dx_pc_out, dx_a_out, dx_b_out;
  logic [W-1:0] mw_ir_out, mw_o_out, mw_d_out;

  pipe_stage_latches #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .fd_en(fd_en), .fd_flush(fd_flush), .fd_ir_in(fd_ir_in), .fd_pc_in(fd_pc_in),
    .fd_ir_out(fd_ir_out), .fd_pc_out(fd_pc_out),
    .dx_en(dx_en), .dx_flush(dx_flush), .dx_ir_in(dx_ir_in), .dx_pc_in(dx_pc_in),
    .dx_a_in(dx_a_in), .dx_b_in(dx_b_in),
    .dx_ir_out(dx_ir_out), .dx_pc_out(dx_pc_out), .dx_a_out(dx_a_out), .dx_b_out(dx_b_out),
    .mw_en(mw_en), .mw_ir_in(mw_ir_in), .mw_o_in(mw_o_in), .mw_d_in(mw_d_in),
    .mw_ir_out(mw_ir_out), .mw_o_out(mw_o_out), .mw_d_out(mw_d_out)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  out_t exp_q[$];
  string fname[NF] = '{"fd_ir", "fd_pc", "dx_ir", "dx_pc", "dx_a", "dx_b", "mw_ir", "mw_o", "mw_d"};

  function automatic in_t mk_in(logic r, logic fe, logic ff, logic de, logic df, logic me,
                                logic [W-1:0] fi, logic [W-1:0] fp, logic [W-1:0] di,
                                logic [W-1:0] dp, logic [W-1:0] da, logic [W-1:0] db,
                                logic [W-1:0] mi, logic [W-1:0] mo, logic [W-1:0] md);
    in_t t;
    t = '{r, fe, ff, de, df, me, fi, fp, di, dp, da, db, mi, mo, md};
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input in_t t);
    @(negedge clock);
    reset    = t.rst;
    fd_en    = t.fd_en;  fd_flush = t.fd_fl;
    dx_en    = t.dx_en;  dx_flush = t.dx_fl;
    mw_en    = t.mw_en;
    fd_ir_in = t.fd_ir;  fd_pc_in = t.fd_pc;
    dx_ir_in = t.dx_ir;  dx_pc_in = t.dx_pc; dx_a_in = t.dx_a; dx_b_in = t.dx_b;
    mw_ir_in = t.mw_ir;  mw_o_in  = t.mw_o;  mw_d_in = t.mw_d;
    @(posedge clock);
    #1;
  endtask

  function automatic out_t dut_outs();
    return {fd_ir_out, fd_pc_out, dx_ir_out, dx_pc_out, dx_a_out, dx_b_out,
            mw_ir_out, mw_o_out, mw_d_out};
  endfunction

  // Compare every field of the outputs against an expected image.
  task automatic check_all(input string tag, input out_t exp);
    out_t act;
    logic [W-1:0] a, e;
    act = dut_outs();
    for (int k = 0; k < NF; k++) begin
      a = act[(NF-1-k)*W +: W];
      e = exp[(NF-1-k)*W +: W];
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s.%s got=%08h expected=%08h", tag, fname[k], a, e);
      end
    end
  endtask

  // ---------------- reference model ----------------
  // Fields are a flat array; each field belongs to a bank. Reset clears all;
  // otherwise an enabled bank copies its inputs, and a flushing bank's first
  // field (its IR) becomes zero.
  function automatic out_t model_step(input out_t cur, input in_t t);
    logic [W-1:0] f[NF];
    logic [W-1:0] x[NF];
    int           bank_of[NF] = '{0, 0, 1, 1, 1, 1, 2, 2, 2};
    int           ir_idx[3]   = '{0, 2, 6};
    logic         en[3];
    logic         fl[3];
    out_t         r;
    en = '{t.fd_en, t.dx_en, t.mw_en};
    fl = '{t.fd_fl, t.dx_fl, 1'b0};
    x  = '{t.fd_ir, t.fd_pc, t.dx_ir, t.dx_pc, t.dx_a, t.dx_b, t.mw_ir, t.mw_o, t.mw_d};
    for (int k = 0; k < NF; k++) begin
      f[k] = cur[(NF-1-k)*W +: W];
      if (t.rst) f[k] = '0;
      else begin
        if (en[bank_of[k]]) f[k] = x[k];
        if (fl[bank_of[k]] && ir_idx[bank_of[k]] == k) f[k] = '0;
      end
    end
    for (int k = 0; k < NF; k++) r[(NF-1-k)*W +: W] = f[k];
    return r;
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [W-1:0] ONES = '1;
  vec_t vecs[9];

  initial begin
    out_t cur;
    in_t  t;
    reset = 1'b1; fd_en = 0; fd_flush = 0; dx_en = 0; dx_flush = 0; mw_en = 0;
    fd_ir_in = 0; fd_pc_in = 0; dx_ir_in = 0; dx_pc_in = 0; dx_a_in = 0; dx_b_in = 0;
    mw_ir_in = 0; mw_o_in = 0; mw_d_in = 0;

    // Directed table. Disabled banks get non-zero junk so a leaking hold shows.
    vecs[0].in  = mk_in(1, 1, 0, 1, 0, 1, ONES, ONES, ONES, ONES, ONES, ONES, ONES, ONES, ONES);
    vecs[0].exp = '0;
    vecs[1].in  = mk_in(0, 1, 0, 0, 0, 0, 32'h28A00005, 32'h11, 32'h99, 32'h98, 32'h97, 32'h96, 32'h95, 32'h94, 32'h93);
    vecs[1].exp = {32'h28A00005, 32'h11, 224'h0};
    vecs[2].in  = mk_in(0, 0, 0, 0, 0, 0, 32'hAAAA5555, 32'h0BBB0000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7);
    vecs[2].exp = {32'h28A00005, 32'h11, 224'h0};
    vecs[3].in  = mk_in(0, 0, 1, 0, 0, 0, 32'h12345678, 32'h20, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7);
    vecs[3].exp = {32'h0, 32'h11, 224'h0};
    vecs[4].in  = mk_in(0, 0, 0, 1, 1, 0, 32'h77, 32'h78, 32'h0842000A, 32'h7, 32'hDEADBEEF, 32'h3, 32'h5, 32'h6, 32'h7);
    vecs[4].exp = {32'h0, 32'h11, 32'h0, 32'h7, 32'hDEADBEEF, 32'h3, 96'h0};
    vecs[5].in  = mk_in(0, 0, 0, 0, 0, 1, 32'h77, 32'h78, 32'h9, 32'h9, 32'h9, 32'h9, 32'h40000004, 32'h10, 32'hCAFEF00D);
    vecs[5].exp = {32'h0, 32'h11, 32'h0, 32'h7, 32'hDEADBEEF, 32'h3, 32'h40000004, 32'h10, 32'hCAFEF00D};
    vecs[6].in  = mk_in(1, 1, 1, 1, 1, 1, ONES, ONES, ONES, ONES, ONES, ONES, ONES, ONES, ONES);
    vecs[6].exp = '0;
    vecs[7].in  = mk_in(0, 0, 0, 1, 0, 0, 32'hF1, 32'hF2, 32'h11111111, 32'h22, 32'h33, 32'h80000044, 32'hE1, 32'hE2, 32'hE3);
    vecs[7].exp = {64'h0, 32'h11111111, 32'h22, 32'h33, 32'h80000044, 96'h0};
    vecs[8].in  = mk_in(0, 1, 1, 0, 1, 0, 32'h5A5A5A5A, 32'h55, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hE1, 32'hE2, 32'hE3);
    vecs[8].exp = {32'h0, 32'h55, 32'h0, 32'h22, 32'h33, 32'h80000044, 96'h0};

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].in);
      check_all($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Hand sequence: X on a disabled bank's inputs must not disturb it.
    t = mk_in(0, 1, 0, 1, 0, 1, 32'hA1, 32'hA2, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hC1, 32'hC2, 32'hC3);
    drive(t);
    check_all("xload", {32'hA1, 32'hA2, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hC1, 32'hC2, 32'hC3});
    t = mk_in(0, 0, 0, 0, 0, 0, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 'x);
    drive(t);
    check_all("xhold", {32'hA1, 32'hA2, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hC1, 32'hC2, 32'hC3});

    // Hand sequence: mid-run reset, then a disabled edge keeps zeros, then
    // the first enabled edge after deassertion loads.
    t = mk_in(1, 0, 0, 0, 0, 0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9);
    drive(t);
    check_all("rst_mid", '0);
    t.rst = 0;
    drive(t);
    check_all("rst_hold", '0);
    t.fd_en = 1; t.dx_en = 1; t.mw_en = 1;
    drive(t);
    check_all("rst_load", {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9});
    cur = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9};

    // Randomized traffic: model predicts, scoreboard queue holds expectation.
    for (int n = 0; n < 400; n++) begin
      t.rst   = ($urandom_range(0, 15) == 0);
      t.fd_en = $urandom_range(0, 1);
      t.fd_fl = ($urandom_range(0, 3) == 0);
      t.dx_en = $urandom_range(0, 1);
      t.dx_fl = ($urandom_range(0, 3) == 0);
      t.mw_en = $urandom_range(0, 1);
      t.fd_ir = $urandom; t.fd_pc = $urandom;
      t.dx_ir = $urandom; t.dx_pc = $urandom; t.dx_a = $urandom; t.dx_b = $urandom;
      t.mw_ir = $urandom; t.mw_o  = $urandom; t.mw_d = $urandom;
      if (!t.rst && !t.mw_en && $urandom_range(0, 3) == 0) begin
        t.mw_ir = 'x; t.mw_o = 'x; t.mw_d = 'x;
      end
      cur = model_step(cur, t);
      exp_q.push_back(cur);
      drive(t);
      check_all($sformatf("rnd%0d", n), exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
